dmem_bus_ctrl: RTL and testbench
================================

Name: dmem_bus_ctrl

Overview:
Parametrised data-memory bus controller between the processor's dmem port and both the synchronous dmem RAM and N_CH memory-mapped peripheral channels, such as VGA framebuffer control, keyboard FIFO and timer. Decodes addresses and aligns RAM read latency. Runs a valid/ready handshake with variable-latency peripherals and stalls the processor while a peripheral access is outstanding. Adds timeout and unmapped-access error reporting.

Parameters:
ADDR_W, 12, processor/RAM word-address width
DATA_W, 32, data width
N_CH, 4, peripheral channel count (1..8)
CH_W, 2, channel-select bits (clog2 of N_CH rounded up, min 1)
RAM_LAT, 1, dmem read latency in cycles (1..3)
TIMEOUT, 15, max cycles waiting for per_ready; 0 disables timeout

Ports:
clock  in  1  master clock, rising edge
reset  in  1  asynchronous, active-high reset
proc_addr  in  ADDR_W  processor address
proc_wdata  in  DATA_W  processor write data
proc_wren  in  1  write request
proc_rden  in  1  read request
proc_stall  out  1  freeze processor
proc_rdata  out  DATA_W  read data, valid with proc_rvalid
proc_rvalid  out  1  one-cycle read-return pulse
ram_addr  out  ADDR_W  dmem address
ram_wdata  out  DATA_W  dmem write data
ram_wren  out  1  dmem write enable
ram_q  in  DATA_W  dmem read data
per_valid  out  N_CH  per-channel request valid
per_wren  out  1  peripheral write (1) / read (0)
per_addr  out  ADDR_W-1-CH_W  peripheral register offset
per_wdata  out  DATA_W  peripheral write data
per_ready  in  N_CH  per-channel accept/complete
per_rdata  in  N_CH*DATA_W  flattened read data, channel c at [c*DATA_W +: DATA_W]
bus_err  out  1  sticky error flag
err_clr  in  1  clears bus_err

Behaviour:
- Map: proc_addr[ADDR_W-1]=0 selects RAM. Otherwise channel = proc_addr[ADDR_W-2 -: CH_W] and offset = the low remaining bits. Channel >= N_CH is unmapped.
- Request means proc_wren|proc_rden, accepted only in IDLE. If both are asserted, the request is a write.
- proc_stall = (state != IDLE). It is a registered decode, so it is high from the cycle after acceptance.
- States: IDLE, RAM_WAIT, PREQ, RESP.
- RAM write: ram_addr/ram_wdata pass through combinationally. ram_wren = proc_wren & RAM-hit & IDLE. No stall; state stays IDLE.
- RAM read: IDLE->RAM_WAIT. A counter runs RAM_LAT cycles. In the last RAM_WAIT cycle, ram_q is captured into proc_rdata and the state goes to RESP.
- Peripheral access: IDLE->PREQ. Address offset, wdata, wren and channel are latched. per_valid[ch]=1 and all other bits are 0. per_* outputs are held stable until the transfer cycle, which is the edge sampling per_ready[ch]=1.
  - Read transfer: capture per_rdata slice, go to RESP.
  - Write transfer: go to IDLE.
- RESP: proc_rvalid=1 for exactly one cycle, proc_rdata held, then IDLE. proc_rdata keeps its value until the next capture.
- Timeout: counter cleared on PREQ entry. If TIMEOUT (nonzero) cycles pass in PREQ without ready:
  - per_valid drops and bus_err is set.
  - A read goes to RESP with proc_rdata=0; a write goes to IDLE.
  - A ready arriving on the timeout cycle counts as success.
- Unmapped access: no per_valid and bus_err is set. A read goes to RESP with rdata=0 (one stall cycle); a write is dropped and the state stays IDLE.
- per_ready on a non-selected channel is ignored.
- bus_err: if set and err_clr occur in the same cycle, set wins.
- Reset (async, any state): state=IDLE, counters=0, proc_stall=0, proc_rvalid=0, proc_rdata=0, per_valid=0, per_wren=0, per_addr=0, per_wdata=0, bus_err=0. An in-flight access is abandoned and no rvalid is issued.
- Reads return exactly one rvalid; writes never produce rvalid.

Decomposition:
- Package dmem_bus_pkg:
  - state encoding (IDLE=0, RAM_WAIT=1, PREQ=2, RESP=3)
  - RAM/peripheral select-bit position
  - TIMEOUT default
  - RESP error data value (0)
- One sub-module, bus_timeout_ctr: clear/enable down-counter with expire pulse and a disable-when-zero parameter. It is reused for the RAM_LAT count.

Test Plan:
- RAM write addr 0x010 data 0xDEADBEEF, then read 0x010 (RAM_LAT=1) -> ram_wren=1 in the same cycle, no stall on the write; the read stalls 2 cycles, then rvalid pulses with 0xDEADBEEF.
- Read 0x805 (ch0 offset 5), per_ready[0] after 3 cycles with 0x12345678 -> per_valid=4'b0001 for 3 cycles and per_addr=5; RESP rvalid data 0x12345678; bus_err=0.
- Write 0xC00 (ch2) data 0xA5 with per_ready[2] tied high -> one PREQ cycle, per_wren=1, per_wdata=0xA5, no rvalid, back to IDLE.
- Read ch1 with per_ready never asserted, TIMEOUT=15 -> after 15 PREQ cycles per_valid=0 and rvalid with data 0; bus_err=1 stays set until err_clr.
- N_CH=3, read channel 3 -> no per_valid, rvalid data 0, bus_err=1. Assert err_clr together with a new unmapped write -> bus_err remains 1.
- Assert reset mid-PREQ while per_ready[0] is toggling -> all outputs 0 immediately, no rvalid after release; the next RAM read completes normally.

Source files
------------

// File: rtl/dmem_bus_pkg.sv
// Shared encodings and constants for the data-memory bus controller.
package dmem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_WAIT = 2'd1,
        ST_PREQ     = 2'd2,
        ST_RESP     = 2'd3
    } bus_state_e;

    localparam int   TIMEOUT_DEFAULT = 15;
    localparam logic RESP_ERR_BIT    = 1'b0;

    // Address bit that separates RAM (0) from peripheral space (1).
    function automatic int sel_bit(input int addr_w);
        return addr_w - 1;
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Clear/enable down-counter: expire_o flags the COUNT-th enabled cycle after clr_i.
// COUNT = 0 disables expiry entirely.
module bus_timeout_ctr #(
    parameter int COUNT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = (COUNT < 2) ? 1 : $clog2(COUNT);
    localparam logic [W-1:0] LOAD = (COUNT == 0) ? '0 : W'(COUNT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (COUNT != 0) && en_i && (cnt_q == '0);

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: routes processor accesses to the synchronous RAM or to
// memory-mapped peripheral channels, stalling the processor while a response is pending.
module dmem_bus_ctrl
    import dmem_bus_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int N_CH    = 4,
    parameter int CH_W    = 2,
    parameter int RAM_LAT = 1,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        proc_addr,
    input  logic [DATA_W-1:0]        proc_wdata,
    input  logic                     proc_wren,
    input  logic                     proc_rden,
    output logic                     proc_stall,
    output logic [DATA_W-1:0]        proc_rdata,
    output logic                     proc_rvalid,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    output logic                     ram_wren,
    input  logic [DATA_W-1:0]        ram_q,
    output logic [N_CH-1:0]          per_valid,
    output logic                     per_wren,
    output logic [ADDR_W-2-CH_W:0]   per_addr,
    output logic [DATA_W-1:0]        per_wdata,
    input  logic [N_CH-1:0]          per_ready,
    input  logic [N_CH*DATA_W-1:0]   per_rdata,
    output logic                     bus_err,
    input  logic                     err_clr,
    output bus_state_e               dbg_state_o
);

    localparam int SEL   = sel_bit(ADDR_W);
    localparam int OFF_W = ADDR_W - 1 - CH_W;
    localparam logic [DATA_W-1:0] ERR_DATA = {DATA_W{RESP_ERR_BIT}};

    bus_state_e        state_q;
    logic [CH_W-1:0]   ch_q;
    logic [DATA_W-1:0] rdata_q;
    logic [N_CH-1:0]   per_valid_q;
    logic              per_wren_q;
    logic [OFF_W-1:0]  per_addr_q;
    logic [DATA_W-1:0] per_wdata_q;
    logic              bus_err_q;

    logic              idle;
    logic              req;
    logic              ram_hit;
    logic              mapped;
    logic [CH_W-1:0]   req_ch;
    logic [N_CH-1:0]   req_onehot;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              ram_start;
    logic              per_start;
    logic              ram_exp;
    logic              to_exp;

    assign idle      = (state_q == ST_IDLE);
    assign req       = proc_wren | proc_rden;
    assign ram_hit   = ~proc_addr[SEL];
    assign req_ch    = proc_addr[ADDR_W-2 -: CH_W];
    assign ram_start = idle & req & ~proc_wren & ram_hit;
    assign per_start = idle & req & ~ram_hit & mapped;

    // Channel decode for new requests, and per_ready/per_rdata of the latched channel only.
    always_comb begin
        mapped     = 1'b0;
        req_onehot = '0;
        sel_ready  = 1'b0;
        sel_rdata  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (req_ch == CH_W'(c)) begin
                mapped        = 1'b1;
                req_onehot[c] = 1'b1;
            end
            if (ch_q == CH_W'(c)) begin
                sel_ready = per_ready[c];
                sel_rdata = per_rdata[c*DATA_W +: DATA_W];
            end
        end
    end

    bus_timeout_ctr #(.COUNT(RAM_LAT)) u_ram_ctr (
        .clk_i    (clock),
        .rst_i    (reset),
        .clr_i    (ram_start),
        .en_i     (state_q == ST_RAM_WAIT),
        .expire_o (ram_exp)
    );

    bus_timeout_ctr #(.COUNT(TIMEOUT)) u_to_ctr (
        .clk_i    (clock),
        .rst_i    (reset),
        .clr_i    (per_start),
        .en_i     (state_q == ST_PREQ),
        .expire_o (to_exp)
    );

    // Handshake: per_valid[ch] and the per_* payload stay stable from PREQ entry until the
    // edge that samples per_ready[ch]=1 (the transfer) or the timeout; ready on that same
    // edge wins over the timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            rdata_q     <= '0;
            per_valid_q <= '0;
            per_wren_q  <= 1'b0;
            per_addr_q  <= '0;
            per_wdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            if (err_clr) begin
                bus_err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (ram_hit) begin
                            if (!proc_wren) begin
                                state_q <= ST_RAM_WAIT;
                            end
                        end else if (mapped) begin
                            state_q     <= ST_PREQ;
                            ch_q        <= req_ch;
                            per_valid_q <= req_onehot;
                            per_wren_q  <= proc_wren;
                            per_addr_q  <= proc_addr[OFF_W-1:0];
                            per_wdata_q <= proc_wdata;
                        end else begin
                            bus_err_q <= 1'b1;
                            if (!proc_wren) begin
                                rdata_q <= ERR_DATA;
                                state_q <= ST_RESP;
                            end
                        end
                    end
                end
                ST_RAM_WAIT: begin
                    if (ram_exp) begin
                        rdata_q <= ram_q;
                        state_q <= ST_RESP;
                    end
                end
                ST_PREQ: begin
                    if (sel_ready || to_exp) begin
                        per_valid_q <= '0;
                        if (!sel_ready) begin
                            bus_err_q <= 1'b1;
                        end
                        if (per_wren_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            rdata_q <= sel_ready ? sel_rdata : ERR_DATA;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign proc_stall  = ~idle;
    assign proc_rvalid = (state_q == ST_RESP);
    assign proc_rdata  = rdata_q;
    assign ram_addr    = proc_addr;
    assign ram_wdata   = proc_wdata;
    assign ram_wren    = idle & proc_wren & ram_hit;
    assign per_valid   = per_valid_q;
    assign per_wren    = per_wren_q;
    assign per_addr    = per_addr_q;
    assign per_wdata   = per_wdata_q;
    assign bus_err     = bus_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl with three peripheral channels, RAM_LAT=1, TIMEOUT=15.
module tb_dmem_bus_ctrl;
    import dmem_bus_pkg::*;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int N_CH    = 3;
    localparam int CH_W    = 2;
    localparam int RAM_LAT = 1;
    localparam int TIMEOUT = 15;
    localparam int OFF_W   = ADDR_W - 1 - CH_W;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [ADDR_W-1:0]      proc_addr;
    logic [DATA_W-1:0]      proc_wdata;
    logic                   proc_wren;
    logic                   proc_rden;
    logic                   proc_stall;
    logic [DATA_W-1:0]      proc_rdata;
    logic                   proc_rvalid;
    logic [ADDR_W-1:0]      ram_addr;
    logic [DATA_W-1:0]      ram_wdata;
    logic                   ram_wren;
    logic [DATA_W-1:0]      ram_q;
    logic [N_CH-1:0]        per_valid;
    logic                   per_wren;
    logic [OFF_W-1:0]       per_addr;
    logic [DATA_W-1:0]      per_wdata;
    logic [N_CH-1:0]        per_ready;
    logic [N_CH*DATA_W-1:0] per_rdata;
    logic                   bus_err;
    logic                   err_clr;
    bus_state_e             dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mon_exp;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    dmem_bus_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_CH(N_CH), .CH_W(CH_W),
        .RAM_LAT(RAM_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_wren(proc_wren), .proc_rden(proc_rden),
        .proc_stall(proc_stall), .proc_rdata(proc_rdata), .proc_rvalid(proc_rvalid),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
        .per_valid(per_valid), .per_wren(per_wren), .per_addr(per_addr), .per_wdata(per_wdata),
        .per_ready(per_ready), .per_rdata(per_rdata),
        .bus_err(bus_err), .err_clr(err_clr), .dbg_state_o(dbg_state)
    );

    // Clock and a one-cycle-latency synchronous RAM model.
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    // Scoreboard: every rvalid pulse must match the oldest expected read return.
    always @(negedge clock) begin
        if (!reset && proc_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL rvalid_spurious got rdata=%h exp no read return", proc_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (proc_rdata !== mon_exp) begin
                    failures++; $display("FAIL rvalid_data got=%h exp=%h", proc_rdata, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic wr, input logic rd);
        proc_addr = a; proc_wdata = d; proc_wren = wr; proc_rden = rd;
    endtask

    task automatic test_reset();
        reset = 1'b1; err_clr = 1'b0; per_ready = '0; per_rdata = '0;
        drive(12'h000, 32'h0, 1'b0, 1'b0);
        #1;
        checks++; if ({proc_stall, proc_rvalid, per_valid, per_wren, bus_err} !== 7'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {proc_stall, proc_rvalid, per_valid, per_wren, bus_err}); end
        checks++; if ({proc_rdata, per_addr, per_wdata} !== '0) begin failures++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h exp=0", proc_rdata, per_addr, per_wdata); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        checks++; if (dbg_state !== ST_IDLE || proc_stall !== 1'b0) begin failures++; $display("FAIL reset_release got state=%0d stall=%b exp=0/0", dbg_state, proc_stall); end
    endtask

    task automatic test_ram();
        drive(12'h010, 32'hDEADBEEF, 1'b1, 1'b0);
        #1;
        checks++; if (ram_wren !== 1'b1 || proc_stall !== 1'b0) begin failures++; $display("FAIL ram_wr got wren=%b stall=%b exp=1/0", ram_wren, proc_stall); end
        checks++; if (ram_addr !== 12'h010 || ram_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_wr_pass got addr=%h data=%h exp=010/deadbeef", ram_addr, ram_wdata); end
        step();
        drive(12'h010, 32'h0, 1'b0, 1'b1);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        checks++; if (proc_stall !== 1'b0 || ram_wren !== 1'b0) begin failures++; $display("FAIL ram_rd_accept got stall=%b wren=%b exp=0/0", proc_stall, ram_wren); end
        step();
        proc_rden = 1'b0;
        checks++; if (dbg_state !== ST_RAM_WAIT || proc_stall !== 1'b1 || proc_rvalid !== 1'b0) begin failures++; $display("FAIL ram_rd_wait got state=%0d stall=%b rvalid=%b exp=1/1/0", dbg_state, proc_stall, proc_rvalid); end
        step();
        checks++; if (dbg_state !== ST_RESP || proc_stall !== 1'b1 || proc_rvalid !== 1'b1) begin failures++; $display("FAIL ram_rd_resp got state=%0d stall=%b rvalid=%b exp=3/1/1", dbg_state, proc_stall, proc_rvalid); end
        step();
        checks++; if (proc_stall !== 1'b0 || proc_rvalid !== 1'b0 || proc_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_rd_done got stall=%b rvalid=%b rdata=%h exp=0/0/deadbeef", proc_stall, proc_rvalid, proc_rdata); end
    endtask

    task automatic test_per_read();
        drive(12'h805, 32'h0, 1'b0, 1'b1);
        exp_q.push_back(32'h12345678);
        step();
        proc_rden = 1'b0;
        per_ready = 3'b010; per_rdata[1*DATA_W +: DATA_W] = 32'hBAD0BAD0;
        checks++; if (dbg_state !== ST_PREQ || per_valid !== 3'b001 || per_addr !== 9'd5 || per_wren !== 1'b0) begin failures++; $display("FAIL per_rd_req got state=%0d valid=%b addr=%0d wren=%b exp=2/001/5/0", dbg_state, per_valid, per_addr, per_wren); end
        step();
        per_ready = 3'b000;
        checks++; if (dbg_state !== ST_PREQ || per_valid !== 3'b001) begin failures++; $display("FAIL per_rd_other_ready got state=%0d valid=%b exp=2/001", dbg_state, per_valid); end
        step();
        per_ready = 3'b001; per_rdata[0 +: DATA_W] = 32'h12345678;
        checks++; if (per_valid !== 3'b001 || proc_stall !== 1'b1) begin failures++; $display("FAIL per_rd_cycle3 got valid=%b stall=%b exp=001/1", per_valid, proc_stall); end
        step();
        per_ready = 3'b000;
        checks++; if (dbg_state !== ST_RESP || per_valid !== 3'b000 || proc_rdata !== 32'h12345678 || bus_err !== 1'b0) begin failures++; $display("FAIL per_rd_resp got state=%0d valid=%b rdata=%h err=%b exp=3/000/12345678/0", dbg_state, per_valid, proc_rdata, bus_err); end
        step();
        checks++; if (proc_stall !== 1'b0) begin failures++; $display("FAIL per_rd_idle got stall=%b exp=0", proc_stall); end
    endtask

    task automatic test_per_write();
        drive(12'hC00, 32'h000000A5, 1'b1, 1'b0);
        per_ready = 3'b100;
        #1;
        checks++; if (ram_wren !== 1'b0) begin failures++; $display("FAIL per_wr_ramwren got=%b exp=0", ram_wren); end
        step();
        proc_wren = 1'b0;
        checks++; if (dbg_state !== ST_PREQ || per_valid !== 3'b100 || per_wren !== 1'b1 || per_wdata !== 32'hA5 || per_addr !== 9'd0) begin failures++; $display("FAIL per_wr_req got state=%0d valid=%b wren=%b wdata=%h addr=%0d exp=2/100/1/a5/0", dbg_state, per_valid, per_wren, per_wdata, per_addr); end
        step();
        per_ready = 3'b000;
        checks++; if (dbg_state !== ST_IDLE || per_valid !== 3'b000 || proc_stall !== 1'b0 || proc_rvalid !== 1'b0) begin failures++; $display("FAIL per_wr_done got state=%0d valid=%b stall=%b rvalid=%b exp=0/000/0/0", dbg_state, per_valid, proc_stall, proc_rvalid); end
    endtask

    task automatic test_timeout();
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL to_pre_err got=%b exp=0", bus_err); end
        drive(12'hA00, 32'h0, 1'b0, 1'b1);
        exp_q.push_back(32'h0);
        step();
        proc_rden = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            checks++; if (dbg_state !== ST_PREQ || per_valid !== 3'b010) begin failures++; $display("FAIL to_wait cycle=%0d got state=%0d valid=%b exp=2/010", k, dbg_state, per_valid); end
            step();
        end
        checks++; if (dbg_state !== ST_RESP || per_valid !== 3'b000 || bus_err !== 1'b1 || proc_rdata !== 32'h0) begin failures++; $display("FAIL to_expire got state=%0d valid=%b err=%b rdata=%h exp=3/000/1/0", dbg_state, per_valid, bus_err, proc_rdata); end
        repeat (4) step();
        checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", bus_err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", bus_err); end
    endtask

    task automatic test_timeout_edge();
        drive(12'h801, 32'h0, 1'b0, 1'b1);
        exp_q.push_back(32'hCAFE0001);
        step();
        proc_rden = 1'b0;
        repeat (TIMEOUT - 1) step();
        per_ready = 3'b001; per_rdata[0 +: DATA_W] = 32'hCAFE0001;
        checks++; if (dbg_state !== ST_PREQ) begin failures++; $display("FAIL to_edge_wait got state=%0d exp=2", dbg_state); end
        step();
        per_ready = 3'b000;
        checks++; if (dbg_state !== ST_RESP || bus_err !== 1'b0 || proc_rdata !== 32'hCAFE0001) begin failures++; $display("FAIL to_edge_resp got state=%0d err=%b rdata=%h exp=3/0/cafe0001", dbg_state, bus_err, proc_rdata); end
        step();
    endtask

    task automatic test_unmapped();
        drive(12'hE00, 32'h0, 1'b0, 1'b1);
        exp_q.push_back(32'h0);
        step();
        proc_rden = 1'b0;
        checks++; if (dbg_state !== ST_RESP || per_valid !== 3'b000 || bus_err !== 1'b1 || proc_stall !== 1'b1 || proc_rdata !== 32'h0) begin failures++; $display("FAIL unmap_rd got state=%0d valid=%b err=%b stall=%b rdata=%h exp=3/000/1/1/0", dbg_state, per_valid, bus_err, proc_stall, proc_rdata); end
        step();
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL unmap_rd_idle got state=%0d exp=0", dbg_state); end
        drive(12'hE04, 32'h00001234, 1'b1, 1'b0);
        err_clr = 1'b1;
        #1;
        checks++; if (ram_wren !== 1'b0) begin failures++; $display("FAIL unmap_wr_ramwren got=%b exp=0", ram_wren); end
        step();
        proc_wren = 1'b0; err_clr = 1'b0;
        checks++; if (dbg_state !== ST_IDLE || proc_stall !== 1'b0 || bus_err !== 1'b1 || per_valid !== 3'b000) begin failures++; $display("FAIL unmap_wr_setwins got state=%0d stall=%b err=%b valid=%b exp=0/0/1/000", dbg_state, proc_stall, bus_err, per_valid); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL unmap_clear got=%b exp=0", bus_err); end
    endtask

    task automatic test_reset_mid_preq();
        drive(12'hE08, 32'h0, 1'b1, 1'b0);
        step();
        drive(12'h803, 32'h00000055, 1'b0, 1'b1);
        step();
        proc_rden = 1'b0;
        checks++; if (dbg_state !== ST_PREQ || per_valid !== 3'b001 || per_addr !== 9'd3 || per_wdata !== 32'h55 || bus_err !== 1'b1) begin failures++; $display("FAIL rst_pre got state=%0d valid=%b addr=%0d wdata=%h err=%b exp=2/001/3/55/1", dbg_state, per_valid, per_addr, per_wdata, bus_err); end
        #2 reset = 1'b1; per_ready = 3'b001;
        #1;
        checks++; if ({proc_stall, proc_rvalid, per_valid, per_wren, bus_err} !== 7'b0 || dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_async_ctrl got=%b state=%0d exp=0/0", {proc_stall, proc_rvalid, per_valid, per_wren, bus_err}, dbg_state); end
        checks++; if ({proc_rdata, per_addr, per_wdata} !== '0) begin failures++; $display("FAIL rst_async_data got rdata=%h addr=%h wdata=%h exp=0", proc_rdata, per_addr, per_wdata); end
        repeat (6) #3 per_ready[0] = ~per_ready[0];
        @(posedge clock);
        #1 reset = 1'b0; per_ready = 3'b000;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (proc_stall !== 1'b0 || proc_rvalid !== 1'b0) begin failures++; $display("FAIL rst_after cycle=%0d got stall=%b rvalid=%b exp=0/0", k, proc_stall, proc_rvalid); end
        end
        drive(12'h010, 32'h0, 1'b0, 1'b1);
        exp_q.push_back(32'hDEADBEEF);
        step();
        proc_rden = 1'b0;
        step();
        checks++; if (proc_rvalid !== 1'b1 || proc_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rst_ram_rd got rvalid=%b rdata=%h exp=1/deadbeef", proc_rvalid, proc_rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_per_read();
        test_per_write();
        test_timeout();
        test_unmapped();
        test_timeout_edge();
        test_reset_mid_preq();
        repeat (2) step();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL missing_rvalid got pending=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
